spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Command-frame decoder directly downstream of the SPI byte receiver, running in the SPI clock domain (w_SPI_Clk).
- Consumes one-cycle received-byte strobes and parses opcode/address/data frames.
- Drives the SPI-clock port of the ROM image RAM for host uploads and readback.
- Returns the readback and status bytes as TX strobes to the SPI byte transmitter.

Parameters:
ADDR_W, 16, RAM address width, 1..16; address bits above ADDR_W-1 are ignored.
STATUS_ID, 4'hA, constant placed in bits [7:4] of the status byte.

Ports:
w_SPI_Clk  input  1  SPI clock; all logic on rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_SPI_CS_n  input  1  chip select; high = asynchronous frame abort
i_RX_DV  input  1  one-cycle strobe, i_RX_Byte valid
i_RX_Byte  input  8  received byte
o_TX_DV  output  1  one-cycle strobe, o_TX_Byte valid
o_TX_Byte  output  8  byte for transmitter
o_Mem_Addr  output  ADDR_W  RAM address
o_Mem_Wdata  output  8  RAM write data
o_Mem_We  output  1  RAM write enable, one cycle per byte
o_Mem_Re  output  1  RAM read enable, one cycle per byte
i_Mem_Rdata  input  8  RAM read data, valid the cycle after o_Mem_Re
o_Config  output  8  configuration register
o_Busy  output  1  state != IDLE
o_Err  output  1  sticky error flag
o_Wrap  output  1  sticky address-wrap flag

Behaviour:
- Reset is i_Rst_L, asynchronous, active-low; clock is w_SPI_Clk. Reset clears all outputs and registers to 0 and sets state to IDLE.
- i_SPI_CS_n high asynchronously forces IDLE and clears o_Mem_We, o_Mem_Re, o_TX_DV and the read pipeline.
- CS abort leaves o_Config, o_Err, o_Wrap, o_TX_Byte and the address register unchanged.
- States: IDLE, ADDR_HI, ADDR_LO, WRITE_DATA, READ_DATA, CONFIG_DATA, DISCARD. Transitions occur only on cycles with i_RX_DV=1.
- IDLE opcode handling:
  - 0x02 WRITE -> ADDR_HI.
  - 0x03 READ -> ADDR_HI.
  - 0x05 STATUS -> DISCARD; next cycle o_TX_DV=1 and o_TX_Byte={STATUS_ID,2'b00,o_Wrap,o_Err}. In that same cycle o_Err clears; o_Wrap is not cleared.
  - 0x06 CONFIG -> CONFIG_DATA.
  - Any other opcode -> DISCARD and o_Err<=1.
- ADDR_HI: addr[15:8] <= byte, masked to ADDR_W. ADDR_LO: addr[7:0] <= byte. Next state is WRITE_DATA or READ_DATA according to the opcode.
- READ start: the ADDR_LO strobe at cycle N issues the first read.
  - N+1: o_Mem_Re=1, o_Mem_Addr=addr.
  - N+2: o_TX_Byte captures i_Mem_Rdata.
  - N+3: o_TX_DV=1.
  - addr increments at the N+1 edge.
- READ_DATA: each further i_RX_DV (dummy byte) starts the next read with the same N+1/N+3 timing at the current addr.
- WRITE_DATA: a strobe at cycle N gives, at N+1, o_Mem_We=1, o_Mem_Addr=addr, o_Mem_Wdata=byte. addr increments after the write.
- Address increment is modulo 2^ADDR_W. Wrapping from all-ones to 0 sets o_Wrap.
- CONFIG_DATA: o_Config <= byte on the next edge, then -> DISCARD.
- DISCARD: ignores all bytes until CS abort. STATUS frames have no further effect after the status byte.
- Successive i_RX_DV strobes are at least 8 cycles apart, so the read pipeline never overlaps itself.
- An i_RX_DV coinciding with CS rising is discarded.
- o_Busy=1 in every state except IDLE.

Optional Feature:
- Macro: SPI_CMD_WRITE_PROTECT_EN.
- Defined:
  - o_Config[0]=1 suppresses o_Mem_We for WRITE_DATA bytes.
  - Each suppressed byte sets o_Err.
  - addr still increments, and wrap is still flagged.
- Undefined: o_Config[0] has no effect on writes; o_Config is a plain register.

Test Plan:
- Reset/idle: assert i_Rst_L=0 mid-frame -> all outputs 0, o_Busy=0, state IDLE.
- Write burst: bytes 02,12,34,AA,BB with 8-cycle spacing -> o_Mem_We pulses with (0x1234,AA) then (0x1235,BB), each 1 cycle after its strobe.
- Read burst: RAM[0x0100]=5A, RAM[0x0101]=C3; send 03,01,00,xx -> o_Mem_Re at 0x0100 then 0x0101; o_TX_Byte 5A then C3, o_TX_DV 3 cycles after each triggering strobe.
- Wrap and status:
  - Write frame 02,FF,FF,11,22 -> writes to 0xFFFF then 0x0000, o_Wrap=1.
  - Frame with opcode 07 -> o_Err=1.
  - STATUS frame 05 -> o_TX_Byte=0xA3, then o_Err=0 and o_Wrap=1.
- CS abort: raise i_SPI_CS_n after 02,12 -> IDLE immediately, no write. A following frame 06,5C -> o_Config=0x5C.
- With SPI_CMD_WRITE_PROTECT_EN: send 06,01 then 02,00,10,77 -> no o_Mem_We, o_Err=1. Same stimulus without the macro -> write (0x0010,77) occurs.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI command-frame decoder: parses opcode/address/data frames into RAM accesses,
// readback and status bytes. Optional macro SPI_CMD_WRITE_PROTECT_EN gates writes with o_Config[0].
module spi_cmd_decoder #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [3:0]  STATUS_ID = 4'hA
) (
  input  logic              w_SPI_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [7:0]        o_Mem_Wdata,
  output logic              o_Mem_We,
  output logic              o_Mem_Re,
  input  logic [7:0]        i_Mem_Rdata,
  output logic [7:0]        o_Config,
  output logic              o_Busy,
  output logic              o_Err,
  output logic              o_Wrap
);

  typedef enum logic [2:0] {
    StIdle, StAddrHi, StAddrLo, StWriteData, StReadData, StConfigData, StDiscard
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       addr_ext;
  logic              is_read_q, op_read;
  logic              mem_we_q, mem_re_q, inc_q, rd_pend_q, tx_dv_q;
  logic [7:0]        wdata_q, tx_byte_q, cfg_q;
  logic              err_q, wrap_q;
  logic              rx_fire, wp;
  logic              ld_hi, ld_lo, wr_go, rd_go, cfg_go, status_go, bad_op;

`ifdef SPI_CMD_WRITE_PROTECT_EN
  assign wp = cfg_q[0];
`else
  assign wp = 1'b0;
`endif

  // A strobe that coincides with CS going high belongs to no frame.
  assign rx_fire = i_RX_DV & ~i_SPI_CS_n;

  always_comb begin
    state_d   = state_q;
    op_read   = is_read_q;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    cfg_go    = 1'b0;
    status_go = 1'b0;
    bad_op    = 1'b0;
    if (rx_fire) begin
      case (state_q)
        StIdle: begin
          case (i_RX_Byte)
            8'h02: begin state_d = StAddrHi; op_read = 1'b0; end
            8'h03: begin state_d = StAddrHi; op_read = 1'b1; end
            8'h05: begin state_d = StDiscard; status_go = 1'b1; end
            8'h06: state_d = StConfigData;
            default: begin state_d = StDiscard; bad_op = 1'b1; end
          endcase
        end
        StAddrHi: begin ld_hi = 1'b1; state_d = StAddrLo; end
        StAddrLo: begin
          ld_lo   = 1'b1;
          rd_go   = is_read_q;
          state_d = is_read_q ? StReadData : StWriteData;
        end
        StWriteData:  wr_go = 1'b1;
        StReadData:   rd_go = 1'b1;
        StConfigData: begin cfg_go = 1'b1; state_d = StDiscard; end
        default: ;
      endcase
    end
  end

  // Address loads and the post-access increment never share a cycle (strobes are spaced).
  always_comb begin
    addr_ext = 16'(addr_q);
    if (ld_hi) addr_ext[15:8] = i_RX_Byte;
    if (ld_lo) addr_ext[7:0] = i_RX_Byte;
    addr_d = addr_ext[ADDR_W-1:0];
    if (inc_q) addr_d = addr_q + ADDR_W'(1);
  end

  // Frame-scoped state: cleared by reset and by a CS abort.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      inc_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      tx_dv_q   <= 1'b0;
    end else if (i_SPI_CS_n) begin
      state_q   <= StIdle;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      inc_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      tx_dv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_we_q  <= wr_go & ~wp;
      mem_re_q  <= rd_go;
      inc_q     <= wr_go | rd_go;
      rd_pend_q <= mem_re_q;
      tx_dv_q   <= rd_pend_q | status_go;
    end
  end

  // Persistent state: survives a CS abort.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      addr_q    <= '0;
      is_read_q <= 1'b0;
      wdata_q   <= 8'h00;
      tx_byte_q <= 8'h00;
      cfg_q     <= 8'h00;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      is_read_q <= op_read;
      if (wr_go) wdata_q <= i_RX_Byte;
      if (rd_pend_q) tx_byte_q <= i_Mem_Rdata;
      else if (status_go) tx_byte_q <= {STATUS_ID, 2'b00, wrap_q, err_q};
      if (cfg_go) cfg_q <= i_RX_Byte;
      if (status_go) err_q <= 1'b0;
      else if (bad_op || (wr_go && wp)) err_q <= 1'b1;
      if (inc_q && (&addr_q)) wrap_q <= 1'b1;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_Wdata = wdata_q;
  assign o_Mem_We    = mem_we_q;
  assign o_Mem_Re    = mem_re_q;
  assign o_Config    = cfg_q;
  assign o_Busy      = (state_q != StIdle);
  assign o_Err       = err_q;
  assign o_Wrap      = wrap_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: expected RAM accesses and TX bytes are queued
// when stimulus is driven and compared, with latency, when the DUT produces them.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cs_n = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  config_reg;
  logic        busy, err, wrap;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  lat;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t tq[$];
  ev_t ev;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc = 0;

  always #5 clk = ~clk;

  spi_cmd_decoder #(.ADDR_W(16), .STATUS_ID(4'hA)) dut (
    .w_SPI_Clk   (clk),
    .i_Rst_L     (rst_l),
    .i_SPI_CS_n  (cs_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_Mem_Addr  (mem_addr),
    .o_Mem_Wdata (mem_wdata),
    .o_Mem_We    (mem_we),
    .o_Mem_Re    (mem_re),
    .i_Mem_Rdata (mem_rdata),
    .o_Config    (config_reg),
    .o_Busy      (busy),
    .o_Err       (err),
    .o_Wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: synchronous read, two preloaded bytes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_dv && !cs_n && rst_l) strobe_cyc <= cyc;
    if (mem_re)
      mem_rdata <= (mem_addr == 16'h0100) ? 8'h5A : (mem_addr == 16'h0101) ? 8'hC3 : 8'h00;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) check("we_unexpected", 32'd1, 32'd0);
      else begin
        ev = wq.pop_front();
        check("we_addr", {16'h0, mem_addr}, {16'h0, ev.addr});
        check("we_data", {24'h0, mem_wdata}, {24'h0, ev.data});
        check("we_latency", cyc - strobe_cyc, {28'h0, ev.lat});
      end
    end
    if (mem_re) begin
      if (rq.size() == 0) check("re_unexpected", 32'd1, 32'd0);
      else begin
        ev = rq.pop_front();
        check("re_addr", {16'h0, mem_addr}, {16'h0, ev.addr});
        check("re_latency", cyc - strobe_cyc, {28'h0, ev.lat});
      end
    end
    if (tx_dv) begin
      if (tq.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else begin
        ev = tq.pop_front();
        check("tx_byte", {24'h0, tx_byte}, {24'h0, ev.data});
        check("tx_latency", cyc - strobe_cyc, {28'h0, ev.lat});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    repeat (7) @(posedge clk);
  endtask

  task automatic push_we(input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e = '{addr: a, data: d, lat: 4'd1};
    wq.push_back(e);
  endtask

  task automatic push_read(input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e = '{addr: a, data: 8'h00, lat: 4'd1};
    rq.push_back(e);
    e = '{addr: 16'h0, data: d, lat: 4'd3};
    tq.push_back(e);
  endtask

  task automatic frame_end();
    @(posedge clk); #1;
    cs_n = 1'b1;
    #1 check("busy_after_cs", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;
    cs_n = 1'b0;
  endtask

  initial begin
    ev_t st;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_config", {24'h0, config_reg}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_wrap", {31'h0, wrap}, 32'd0);
    check("rst_tx_dv", {31'h0, tx_dv}, 32'd0);
    @(posedge clk); #1 cs_n = 1'b0;

    // Write burst
    send(8'h02);
    check("busy_in_frame", {31'h0, busy}, 32'd1);
    send(8'h12);
    send(8'h34);
    push_we(16'h1234, 8'hAA);
    send(8'hAA);
    push_we(16'h1235, 8'hBB);
    send(8'hBB);
    frame_end();

    // Read burst
    send(8'h03);
    send(8'h01);
    push_read(16'h0100, 8'h5A);
    send(8'h00);
    push_read(16'h0101, 8'hC3);
    send(8'hEE);
    frame_end();

    // Wrap
    send(8'h02);
    send(8'hFF);
    send(8'hFF);
    check("wrap_before", {31'h0, wrap}, 32'd0);
    push_we(16'hFFFF, 8'h11);
    send(8'h11);
    check("wrap_set", {31'h0, wrap}, 32'd1);
    push_we(16'h0000, 8'h22);
    send(8'h22);
    frame_end();

    // Bad opcode
    check("err_before", {31'h0, err}, 32'd0);
    send(8'h07);
    check("err_badop", {31'h0, err}, 32'd1);
    frame_end();

    // Status
    st = '{addr: 16'h0, data: 8'hA3, lat: 4'd1};
    tq.push_back(st);
    send(8'h05);
    check("err_after_status", {31'h0, err}, 32'd0);
    check("wrap_after_status", {31'h0, wrap}, 32'd1);
    frame_end();

    // CS abort mid-address, then config
    send(8'h02);
    send(8'h12);
    frame_end();
    send(8'h06);
    send(8'h5C);
    check("config_5c", {24'h0, config_reg}, 32'h5C);
    frame_end();

    // Write-protect bit
    send(8'h06);
    send(8'h01);
    check("config_01", {24'h0, config_reg}, 32'h01);
    frame_end();
    send(8'h02);
    send(8'h00);
    send(8'h10);
`ifndef SPI_CMD_WRITE_PROTECT_EN
    push_we(16'h0010, 8'h77);
`endif
    send(8'h77);
`ifdef SPI_CMD_WRITE_PROTECT_EN
    check("err_wp", {31'h0, err}, 32'd1);
`else
    check("err_no_wp", {31'h0, err}, 32'd0);
`endif
    frame_end();

    // Reset mid-frame
    send(8'h03);
    send(8'h12);
    #1 rst_l = 1'b0;
    #1;
    check("mrst_busy", {31'h0, busy}, 32'd0);
    check("mrst_config", {24'h0, config_reg}, 32'd0);
    check("mrst_wrap", {31'h0, wrap}, 32'd0);
    check("mrst_err", {31'h0, err}, 32'd0);
    check("mrst_tx_byte", {24'h0, tx_byte}, 32'd0);
    check("mrst_addr", {16'h0, mem_addr}, 32'd0);
    check("mrst_we", {31'h0, mem_we}, 32'd0);
    check("mrst_re", {31'h0, mem_re}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    repeat (4) @(posedge clk);

    check("we_left", wq.size(), 32'd0);
    check("re_left", rq.size(), 32'd0);
    check("tx_left", tq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
